// File: rtl/pipelined_rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder and related arithmetic blocks.
package pipelined_rca_pkg;

  // Legal configuration: at least one bit and one stage, with stages dividing the width evenly.
  function automatic bit rca_cfg_legal(input int unsigned n, input int unsigned stages);
    return (n >= 1) && (stages >= 1) && ((n % stages) == 0);
  endfunction

  // Bits handled by each pipeline segment (guarded so an illegal STAGES=0 cannot divide by zero).
  function automatic int unsigned rca_seg_width(input int unsigned n, input int unsigned stages);
    return (stages == 0) ? 0 : (n / stages);
  endfunction

  // Two's-complement overflow: the carry into the sign bit disagrees with the carry out of it.
  function automatic logic rca_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Gate-level single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic c_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (sum, ab_x, cin);
  and g_a1 (ab_a, a, b);
  and g_a2 (c_a, ab_x, cin);
  or  g_o1 (cout, ab_a, c_a);

endmodule

// File: rtl/pipelined_rca_segment.sv
// Combinational W-bit ripple adder segment built from full_adder cells.
module rca_segment #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined N-bit ripple-carry adder/subtractor with valid/ready handshake and global stall.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned W = rca_seg_width(N, STAGES);

  if (!rca_cfg_legal(N, STAGES)) begin : g_illegal
    $error("pipelined_rca: illegal configuration N=%0d STAGES=%0d (need N>=1, STAGES>=1, STAGES divides N)",
           N, STAGES);
  end

  logic         stall;
  logic [N-1:0] b_eff;
  logic         c0;

  // Subtract is a + ~b + ~cin: invert B and the incoming carry together.
  assign b_eff = b ^ {N{sub}};
  assign c0    = cin ^ sub;

  // Each stage carries one N-bit word: finished sum segments below its slice, raw A above it.
  // Effective B travels in a word that sheds its consumed low segment at every stage, so the
  // operand skew and the result deskew both fall out of these two shifting words.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * W;
    localparam int unsigned YI = N - LO;

    logic [N-1:0]  x_in;
    logic [N-1:0]  x_d;
    logic [N-1:0]  x_q;
    logic [YI-1:0] y_in;
    logic          c_in;
    logic          v_in;
    logic [W-1:0]  seg_sum;
    logic          seg_cout;
    logic          seg_cmsb;
    logic          c_d;
    logic          c_q;
    logic          v_d;
    logic          v_q;

    if (s == 0) begin : g_src
      assign x_in = a;
      assign y_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;
    end else begin : g_src
      assign x_in = g_stage[s-1].x_q;
      assign y_in = g_stage[s-1].g_skew.y_q;
      assign c_in = g_stage[s-1].c_q;
      assign v_in = g_stage[s-1].v_q;
    end

    rca_segment #(.W(W)) u_seg (
      .a    (x_in[LO +: W]),
      .b    (y_in[W-1:0]),
      .cin  (c_in),
      .sum  (seg_sum),
      .cout (seg_cout),
      .c_msb(seg_cmsb)
    );

    // Advance this stage's word, carry and valid unless the output is stalled.
    always_comb begin
      x_d = x_q;
      c_d = c_q;
      v_d = v_q;
      if (!stall) begin
        x_d          = x_in;
        x_d[LO +: W] = seg_sum;
        c_d          = seg_cout;
        v_d          = v_in;
      end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else begin
        x_q <= x_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end

    if (s + 1 < STAGES) begin : g_skew
      localparam int unsigned YO = YI - W;

      logic [YO-1:0] y_d;
      logic [YO-1:0] y_q;
      logic          unused_cmsb;

      assign unused_cmsb = seg_cmsb;

      // Pass the not-yet-consumed effective-B segments on to later stages.
      always_comb begin
        y_d = y_q;
        if (!stall) y_d = y_in[YI-1:W];
      end

      // Effective-B skew register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= '0;
        else        y_q <= y_d;
      end
    end else begin : g_last
      logic cmsb_d;
      logic cmsb_q;

      // Capture the carry into bit N-1 alongside the final carry-out for overflow.
      always_comb begin
        cmsb_d = cmsb_q;
        if (!stall) cmsb_d = seg_cmsb;
      end

      // Carry-into-MSB register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmsb_q <= 1'b0;
        else        cmsb_q <= cmsb_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].x_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = rca_ovf(g_stage[STAGES-1].g_last.cmsb_q, g_stage[STAGES-1].c_q);
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: directed 8-bit vectors and sequences, random 16-bit runs.
module tb_pipelined_rca;

  logic clk;
  logic rst_n;

  // N=8, STAGES=4 instance
  logic       iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  // N=16 instances: [0] STAGES=1, [1] STAGES=16, shared inputs
  logic        iv16, or16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        ir16   [2];
  logic        ov16   [2];
  logic [15:0] s16    [2];
  logic        cout16 [2];
  logic        ovf16  [2];

  int n_tests;
  int n_fail;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec8_t;

  typedef struct {
    logic [17:0] exp;
    int unsigned adv;
  } sb_t;

  vec8_t       vecs [11];
  sb_t         sbq  [2][$];
  int unsigned adv  [2];
  int unsigned st_of[2];

  pipelined_rca #(.N(8), .STAGES(4)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  pipelined_rca #(.N(16), .STAGES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[0]), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16[0]), .out_ready(or16), .sum(s16[0]),
    .cout(cout16[0]), .ovf(ovf16[0])
  );

  pipelined_rca #(.N(16), .STAGES(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16[1]), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16[1]), .out_ready(or16), .sum(s16[1]),
    .cout(cout16[1]), .ovf(ovf16[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} for a 16-bit add/subtract.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] full;
    logic [15:0] low;
    bb   = sub ? ~b : b;
    c0   = cin ^ sub;
    full = {1'b0, a} + {1'b0, bb} + 17'(c0);
    low  = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + 16'(c0);
    return {low[15] ^ full[16], full[16], full[15:0]};
  endfunction

  // Issue one 8-bit operation and count clock edges until out_valid (bounded).
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int issued;
    int got;
    int hold;
    int extra;
    bit stalled_once;

    n_tests = 0;
    n_fail  = 0;

    //           a      b      cin   sub   sum    cout  ovf
    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
    vecs[6]  = '{8'h0A, 8'h03, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0};
    vecs[7]  = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    st_of[0] = 1;
    st_of[1] = 16;
    adv[0]   = 0;
    adv[1]   = 0;

    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_out_valid8", ov8, 0);
    check("reset_in_ready8", ir8, 1);
    check("reset_sum8", {ovf8, cout8, sum8}, 0);
    check("reset_out_valid_s1", ov16[0], 0);
    check("reset_out_valid_s16", ov16[1], 0);
    rst_n = 1'b1;

    // Directed vector table, N=8 STAGES=4
    for (int i = 0; i < 11; i++) begin
      issue8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i), sum8, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), cout8, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d_single_pulse", i), ov8, 0);
    end

    // Six back-to-back ops, 3-cycle stall on first result; op i: a=16*i, b=i -> sum 0x11*i
    issued = 0; got = 0; hold = 0; stalled_once = 0;
    or8 = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (ov8 && !stalled_once) begin
        stalled_once = 1;
        hold = 3;
      end
      if (hold > 0) begin
        or8 = 1'b0;
        #1;
        check("stall_in_ready", ir8, 0);
        check("stall_hold_valid", ov8, 1);
        check("stall_hold_sum", sum8, 8'h11);
        hold--;
      end else begin
        or8 = 1'b1;
        #1;
        if (ov8) begin
          got++;
          check($sformatf("order_sum%0d", got), sum8, 8'(8'h11 * got));
        end
      end
      if (issued < 6 && ir8) begin
        issued++;
        a8 = 8'(16 * issued); b8 = 8'(issued); cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
    end
    iv8 = 1'b0;
    check("stall_all_delivered", got, 6);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov8) extra++;
    end
    check("stall_no_duplicates", extra, 0);

    // Asynchronous reset with three operations in flight
    or8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = 8'(i + 1); b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
    end
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
    #2;
    check("rst_pre_valid", ov8, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", ov8, 0);
    check("rst_async_ready", ir8, 1);
    check("rst_async_result", {ovf8, cout8, sum8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov8) extra++;
    end
    check("rst_no_ghost_results", extra, 0);
    issue8(8'h22, 8'h11, 1'b0, 1'b0, lat);
    check("rst_new_latency", lat, 4);
    check("rst_new_sum", sum8, 8'h33);

    // Random run on N=16 STAGES=1 and STAGES=16 with random in_valid/out_ready
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      sub16 = 1'($urandom_range(0, 1));
      iv16  = ($urandom_range(0, 3) != 0);
      or16  = ($urandom_range(0, 3) != 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        bit exp_v;
        exp_v = (sbq[d].size() > 0) && ((adv[d] - sbq[d][0].adv) == st_of[d]);
        check($sformatf("rand_s%0d_valid", st_of[d]), ov16[d], exp_v);
        check($sformatf("rand_s%0d_in_ready", st_of[d]), ir16[d], !(ov16[d] && !or16));
        if (exp_v && ov16[d]) begin
          check($sformatf("rand_s%0d_result", st_of[d]), {ovf16[d], cout16[d], s16[d]},
                sbq[d][0].exp);
          if (or16) void'(sbq[d].pop_front());
        end
        if (iv16 && ir16[d])
          sbq[d].push_back('{exp: model16(a16, b16, cin16, sub16), adv: adv[d]});
        if (!(ov16[d] && !or16)) adv[d]++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
